// File: rtl/hazard_unit_sb.sv
// Hazard unit: forwarding, load-use stall, branch flush, MDU scoreboard.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_unit_sb #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_mdu,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rf_en,
  input  logic              ex_is_load,
  input  logic              ex_is_mdu,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rf_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_rf_en,
  input  logic              br_taken,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              mdu_busy,
  output logic              mdu_wb_valid,
  output logic [REG_AW-1:0] mdu_wb_rd
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_lw_cnt,
  output logic [CNT_W-1:0]  perf_sb_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

  localparam int NUM_REGS = 2**REG_AW;
  localparam logic [3:0] LAT = 4'(MDU_LAT);

  if (MDU_LAT < 1 || MDU_LAT > 15 || CNT_W < 1) begin : g_param_chk
    $error("hazard_unit_sb: illegal MDU_LAT or CNT_W");
  end

  logic [NUM_REGS-1:0] sb;
  logic [3:0]          cnt;
  logic                issue;
  logic                done;
  logic                stall_lw;
  logic                stall_sb;
  logic                stall;
  logic                ex_wr;
  logic                ex_hit;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_en,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_en
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (m_en && m_rd == rs)
        sel = 2'b01;
      else if (w_en && w_rd == rs)
        sel = 2'b10;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(ex_rs1, mem_rd, mem_rf_en, wb_rd, wb_rf_en);
  assign fwd_b = fwd_sel(ex_rs2, mem_rd, mem_rf_en, wb_rd, wb_rf_en);

  assign ex_wr  = ex_rf_en && ex_rd != '0;
  assign ex_hit = ex_rd == id_rs1 || ex_rd == id_rs2;

  assign stall_lw = ex_is_load && ex_wr && ex_hit;

  // sb[0] is never set, so x0 operands cannot stall
  assign stall_sb = sb[id_rs1] || sb[id_rs2] || sb[id_rd]
                 || (ex_is_mdu && ex_wr && (ex_hit || ex_rd == id_rd))
                 || (id_is_mdu && (mdu_busy || ex_is_mdu));

  assign stall       = stall_lw || stall_sb;
  assign stall_if    = stall && !br_taken;
  assign stall_id    = stall && !br_taken;
  assign flush_id_ex = stall || br_taken;
  assign flush_if_id = br_taken;

  assign issue        = ex_is_mdu && !mdu_busy;
  assign done         = mdu_busy && cnt == 4'd1;
  assign mdu_wb_valid = done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb        <= '0;
      cnt       <= '0;
      mdu_busy  <= 1'b0;
      mdu_wb_rd <= '0;
    end else if (issue) begin
      cnt       <= LAT;
      mdu_busy  <= 1'b1;
      mdu_wb_rd <= ex_rd;
      if (ex_wr)
        sb[ex_rd] <= 1'b1;
    end else if (mdu_busy) begin
      cnt <= cnt - 4'd1;
      if (done) begin
        mdu_busy      <= 1'b0;
        sb[mdu_wb_rd] <= 1'b0;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lw_cnt    <= '0;
      perf_sb_cnt    <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_lw && perf_lw_cnt != '1)
        perf_lw_cnt <= perf_lw_cnt + CNT_W'(1);
      if (stall_sb && perf_sb_cnt != '1)
        perf_sb_cnt <= perf_sb_cnt + CNT_W'(1);
      if (br_taken && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
- Next-generation pipeline hazard unit for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Adds two-level forwarding (MEM and WB sources), load-use stall and branch flush.
- Adds a per-register scoreboard for a non-pipelined multi-cycle MUL/DIV unit (MDU) with parametrised latency.
- Sits beside the ID/EX pipeline register; drives the stall/flush inputs of the pipeline registers and the EX operand muxes.

Parameters:
- REG_AW, 5, register address width; NUM_REGS = 2**REG_AW.
- MDU_LAT, 4, MDU result latency in cycles; legal range 1..15.
- CNT_W, 16, width of each performance counter; used only with HAZARD_PERF_EN.

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- id_rs1  input  REG_AW  rs1 of the instruction in ID
- id_rs2  input  REG_AW  rs2 of the instruction in ID
- id_rd  input  REG_AW  rd of the instruction in ID
- id_is_mdu  input  1  instruction in ID is a MUL/DIV
- ex_rs1  input  REG_AW  rs1 of the instruction in EX
- ex_rs2  input  REG_AW  rs2 of the instruction in EX
- ex_rd  input  REG_AW  rd of the instruction in EX
- ex_rf_en  input  1  instruction in EX writes the register file
- ex_is_load  input  1  instruction in EX is a load (sel_wb == 2'b01)
- ex_is_mdu  input  1  instruction in EX issues to the MDU
- mem_rd  input  REG_AW  rd in MEM
- mem_rf_en  input  1  MEM writes the register file
- wb_rd  input  REG_AW  rd in WB
- wb_rf_en  input  1  WB writes the register file
- br_taken  input  1  branch/jump resolved taken in EX
- fwd_a  output  2  EX operand A source: 00 RF, 01 MEM, 10 WB
- fwd_b  output  2  EX operand B source, same encoding as fwd_a
- stall_if  output  1  hold the PC
- stall_id  output  1  hold the IF/ID register
- flush_if_id  output  1  bubble into IF/ID
- flush_id_ex  output  1  bubble into ID/EX
- mdu_busy  output  1  MDU operation in flight
- mdu_wb_valid  output  1  one-cycle pulse: MDU result ready
- mdu_wb_rd  output  REG_AW  destination register of the completing MDU op

Behaviour:
- Reset (rst_n = 0 at a clk edge): scoreboard all 0, MDU counter 0, mdu_busy 0, mdu_wb_valid 0, mdu_wb_rd 0, perf counters 0.
- Combinational outputs follow their inputs immediately after reset.
- Forwarding (combinational), evaluated independently for ex_rs1 → fwd_a and ex_rs2 → fwd_b:
  - 01 if mem_rf_en, mem_rd == rs and rs != 0.
  - Else 10 if wb_rf_en, wb_rd == rs and rs != 0.
  - Else 00.
  - MEM has priority over WB.
- stall_lw: ex_is_load & ex_rf_en & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2).
- Scoreboard: busy[NUM_REGS]; busy[0] is always 0.
- MDU issue is accepted when ex_is_mdu & !mdu_busy. On acceptance:
  - Latch the counter to MDU_LAT.
  - mdu_busy = 1 from the next cycle.
  - Latch rd into mdu_wb_rd.
  - Set busy[ex_rd] if ex_rf_en & ex_rd != 0.
- An issue while mdu_busy is ignored; stall_sb prevents this in normal operation.
- Counter decrements each cycle while busy. Issue at cycle t gives:
  - mdu_wb_valid = 1 at cycle t+MDU_LAT (MDU_LAT = 1 → pulse at t+1).
  - On the edge ending that cycle: busy[rd] clears and mdu_busy falls.
  - A new issue is accepted at t+MDU_LAT+1 at the earliest.
- stall_sb (combinational). Asserted if any of:
  - busy[id_rs1], busy[id_rs2] or busy[id_rd] (RAW/WAW);
  - ex_is_mdu & ex_rf_en & ex_rd != 0 & ex_rd matches id_rs1, id_rs2 or id_rd (issue-cycle bypass);
  - id_is_mdu & (mdu_busy | ex_is_mdu) (structural).
- Source operands equal to 0 never cause a stall.
- Stall and flush outputs:
  - stall = stall_lw | stall_sb.
  - stall_if = stall_id = stall & !br_taken.
  - flush_id_ex = stall | br_taken.
  - flush_if_id = br_taken.
  - br_taken wins over a stall in the same cycle, because the stalled instructions are squashed.
- br_taken does not cancel an in-flight MDU operation; the branch is younger than it.
- Reset asserted mid-operation abandons the MDU operation: no mdu_wb_valid pulse, and the scoreboard clears.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, add outputs perf_lw_cnt, perf_sb_cnt and perf_flush_cnt, each CNT_W wide.
- They count the cycles in which stall_lw, stall_sb and br_taken respectively are high.
- Each counter saturates at all-ones and resets to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- ex_rs1 = 5, mem_rd = 5, mem_rf_en = 1, wb_rd = 5, wb_rf_en = 1 → fwd_a = 01. Drop mem_rf_en → fwd_a = 10. Set ex_rs1 = 0 → fwd_a = 00.
- ex_is_load = 1, ex_rf_en = 1, ex_rd = 7, id_rs2 = 7 → stall_if = stall_id = flush_id_ex = 1 for that cycle. With ex_rd = 0 → all 0.
- MDU_LAT = 4: issue ex_rd = 9 at t with id_rs1 = 9 held → stall_id high at t..t+4, mdu_wb_valid = 1 with mdu_wb_rd = 9 only at t+4, stall low at t+5.
- MDU in flight plus id_is_mdu = 1 → structural stall until mdu_busy falls. The second issue at t+5 is accepted and pulses at t+9.
- Load-use stall and br_taken in the same cycle → stall_if = 0, flush_if_id = 1, flush_id_ex = 1.
- rst_n = 0 at t+2 of an MDU op → mdu_busy = 0 and no pulse afterwards. With HAZARD_PERF_EN, the counters read 0, then perf_sb_cnt = 3 after 3 scoreboard stall cycles.
